// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, write-back destination encodings and the
// result-sink state enum. Also used by the ALU and control unit.
package alu_pkg;

   localparam logic [4:0] OP_OR   = 5'd0;
   localparam logic [4:0] OP_AND  = 5'd1;
   localparam logic [4:0] OP_ADD  = 5'd2;
   localparam logic [4:0] OP_SUB  = 5'd3;
   localparam logic [4:0] OP_XOR  = 5'd4;
   localparam logic [4:0] OP_NOR  = 5'd5;
   localparam logic [4:0] OP_SLT  = 5'd6;
   localparam logic [4:0] OP_SLL  = 5'd7;
   localparam logic [4:0] OP_SRL  = 5'd8;
   localparam logic [4:0] OP_SRA  = 5'd9;
   localparam logic [4:0] OP_MULT = 5'd10;
   localparam logic [4:0] OP_DIV  = 5'd11;

   localparam logic [1:0] SEL_Z  = 2'd0;
   localparam logic [1:0] SEL_LO = 2'd1;
   localparam logic [1:0] SEL_HI = 2'd2;

   localparam int CNT_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_CAPTURE,
      ST_EMIT_LO,
      ST_EMIT_HI
   } state_e;

   // Multiply and divide produce a full 64-bit result written as two beats.
   function automatic logic is_wide(input logic [4:0] op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/settle_counter.sv
// Loadable down-counter timing the ALU settle window; done flags the last cycle.
module settle_counter
   import alu_pkg::*;
(
   input  logic             clock,
   input  logic             clear,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic [CNT_W-1:0] count,
   output logic             done
);

   always_ff @(posedge clock) begin
      if (clear)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (en && count != '0)
         count <= count - 1'b1;
   end

   assign done = (count == CNT_W'(1));

endmodule

// File: rtl/alu_result_sink.sv
// ALU result capture and write-back stage: settle, latch C into zhi/zlo, emit
// one or two beats. Optional divide-by-zero suppression: ALU_DIVZERO_CHK_EN.
module alu_result_sink
   import alu_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1,
   parameter int MULDIV_CYCLES = 4
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        start,
   input  logic [4:0]  op,
   input  logic [31:0] b_in,
   input  logic [63:0] c_in,
   output logic        busy,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [1:0]  out_sel,
   output logic [31:0] zhi,
   output logic [31:0] zlo,
   output logic        div_zero
);

   state_e           state, state_nxt;
   logic [4:0]       op_q;
   logic             load, capture, dz_nxt, wide;
   logic [CNT_W-1:0] load_val, count;
   logic             done;
   logic [31:0]      zhi_d, zlo_d;

   assign wide     = is_wide(op_q);
   assign load_val = is_wide(op) ? CNT_W'(MULDIV_CYCLES) : CNT_W'(SETTLE_CYCLES);

   settle_counter u_cnt (
      .clock    (clock),
      .clear    (clear),
      .load     (load),
      .load_val (load_val),
      .en       (state == ST_SETTLE),
      .count    (count),
      .done     (done)
   );

`ifdef ALU_DIVZERO_CHK_EN
   logic [31:0] b_q;
`else
   logic unused_b_in;
   assign unused_b_in = ^b_in;
`endif

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      capture   = 1'b0;
      dz_nxt    = 1'b0;
      case (state)
         ST_IDLE:    if (start) begin
                        state_nxt = ST_SETTLE;
                        load      = 1'b1;
                     end
         ST_SETTLE:  if (done) state_nxt = ST_CAPTURE;
         ST_CAPTURE: begin
                        state_nxt = ST_EMIT_LO;
                        capture   = 1'b1;
`ifdef ALU_DIVZERO_CHK_EN
                        if (op_q == OP_DIV && b_q == '0) begin
                           state_nxt = ST_IDLE;
                           capture   = 1'b0;
                           dz_nxt    = 1'b1;
                        end
`endif
                     end
         ST_EMIT_LO: if (out_ready) state_nxt = wide ? ST_EMIT_HI : ST_IDLE;
         ST_EMIT_HI: if (out_ready) state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   assign zhi_d = capture ? c_in[63:32] : zhi;
   assign zlo_d = capture ? c_in[31:0]  : zlo;

   // Outputs are registered off next-state so a beat appears the cycle after CAPTURE.
   always_ff @(posedge clock) begin
      if (clear) begin
         state     <= ST_IDLE;
         op_q      <= '0;
         zhi       <= '0;
         zlo       <= '0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= SEL_Z;
      end else begin
         state     <= state_nxt;
         if (state == ST_IDLE && start) op_q <= op;
         zhi       <= zhi_d;
         zlo       <= zlo_d;
         busy      <= (state_nxt != ST_IDLE);
         out_valid <= (state_nxt == ST_EMIT_LO) || (state_nxt == ST_EMIT_HI);
         case (state_nxt)
            ST_EMIT_LO: begin
                           out_data <= zlo_d;
                           out_sel  <= wide ? SEL_LO : SEL_Z;
                        end
            ST_EMIT_HI: begin
                           out_data <= zhi_d;
                           out_sel  <= SEL_HI;
                        end
            default:    begin
                           out_data <= '0;
                           out_sel  <= SEL_Z;
                        end
         endcase
      end
   end

`ifdef ALU_DIVZERO_CHK_EN
   always_ff @(posedge clock) begin
      if (clear) begin
         b_q      <= '0;
         div_zero <= 1'b0;
      end else begin
         if (state == ST_IDLE && start) b_q <= b_in;
         div_zero <= dz_nxt;
      end
   end
`else
   assign div_zero = 1'b0;
`endif

endmodule
